// File: rtl/uart_frame_sched.sv
// Frame scheduler between uart_rx, a shared sync byte FIFO and uart_tx.
// Optional idle-flush timer in FILL: define UART_FRAME_SCHED_TIMEOUT_EN.
module uart_frame_sched #(
    parameter int             DW          = 8,
    parameter int             CW          = 5,
    parameter int             THRESH      = 8,
    parameter logic [DW-1:0]  TERM_BYTE   = 8'h0D,
    parameter int             TIMEOUT_CYC = 52080
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_vld,
    input  logic [DW-1:0] rx_data,
    output logic          fifo_wr_en,
    output logic [DW-1:0] fifo_wdata,
    input  logic          fifo_full,
    output logic          fifo_rd_en,
    input  logic [DW-1:0] fifo_rdata,
    input  logic          fifo_empty,
    output logic          tx_start,
    output logic [DW-1:0] tx_data,
    input  logic          tx_busy,
    input  logic          ovf_clr,
    output logic          ovf_err,
    output logic          frame_done,
    output logic [CW-1:0] occupancy
);

    localparam int DEPTH = 2 ** (CW - 1);

    typedef enum logic [2:0] {IDLE, FILL, RD, LOAD, WAIT_HI, WAIT_LO} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [DW-1:0] tx_data_q, tx_data_d;
    logic          tx_start_q, tx_start_d;
    logic          frame_done_q, frame_done_d;
    logic          ovf_q, ovf_d;
    logic          trig;
    logic          timeout;

    assign fifo_wr_en = rx_vld & ~fifo_full;
    assign fifo_wdata = rx_data;
    // Kept out of the FSM process so occupancy/trig do not loop back through it.
    assign fifo_rd_en = (state_q == RD);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        occ_d = occ_q;
        if (fifo_wr_en && !fifo_rd_en && occ_q != CW'(DEPTH))
            occ_d = occ_q + 1'b1;
        else if (!fifo_wr_en && fifo_rd_en && occ_q != '0)
            occ_d = occ_q - 1'b1;
    end

    assign trig = (fifo_wr_en && rx_data == TERM_BYTE) || (occ_d >= CW'(THRESH));

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr)
            ovf_d = 1'b0;
        if (rx_vld && fifo_full)
            ovf_d = 1'b1;
    end

`ifdef UART_FRAME_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] idle_cnt_q, idle_cnt_d;

    always_comb begin
        idle_cnt_d = '0;
        if (state_q == FILL && !rx_vld)
            idle_cnt_d = idle_cnt_q + 1'b1;
    end

    assign timeout = (state_q == FILL) && !rx_vld && (idle_cnt_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_cnt_q <= '0;
        else
            idle_cnt_q <= idle_cnt_d;
    end
`else
    // No flush timer: a partial frame waits for a terminator or the threshold.
    assign timeout = (TIMEOUT_CYC < 0);
`endif

    always_comb begin
        state_d      = state_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            IDLE:    if (fifo_wr_en) state_d = trig ? RD : FILL;
            FILL:    if (trig || timeout) state_d = RD;
            RD:      state_d = LOAD;
            LOAD: begin
                tx_data_d  = fifo_rdata;
                tx_start_d = 1'b1;
                state_d    = WAIT_HI;
            end
            WAIT_HI: if (tx_busy) state_d = WAIT_LO;
            WAIT_LO: begin
                // A byte written in this very cycle is not yet visible on fifo_empty.
                if (!tx_busy) begin
                    if (fifo_empty && !fifo_wr_en) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            occ_q        <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            occ_q        <= occ_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            frame_done_q <= frame_done_d;
            ovf_q        <= ovf_d;
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign frame_done = frame_done_q;
    assign ovf_err    = ovf_q;
    assign occupancy  = occ_q;

endmodule

// File: tb/tb_uart_frame_sched.sv
// Self-checking bench for uart_frame_sched: behavioural FIFO and transmitter
// models, a byte scoreboard checked at every tx_start.
module tb_uart_frame_sched;

    localparam int DW     = 8;
    localparam int CW     = 5;
    localparam int THRESH = 8;
    localparam int DEPTH  = 16;
    localparam int T_CYC  = 200;
    localparam int TX_CYC = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_vld = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          fifo_wr_en, fifo_rd_en, fifo_full, fifo_empty;
    logic [DW-1:0] fifo_wdata, fifo_rdata, tx_data;
    logic          tx_start, tx_busy, ovf_err, frame_done;
    logic          ovf_clr = 1'b0;
    logic          hold_busy = 1'b0;
    logic [CW-1:0] occupancy;

    always #10 clk = ~clk;

    uart_frame_sched #(
        .DW(DW), .CW(CW), .THRESH(THRESH), .TERM_BYTE(8'h0D), .TIMEOUT_CYC(T_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_vld(rx_vld), .rx_data(rx_data),
        .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
        .fifo_rd_en(fifo_rd_en), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .ovf_clr(ovf_clr), .ovf_err(ovf_err), .frame_done(frame_done),
        .occupancy(occupancy)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // FIFO model: registered read data, valid the cycle after fifo_rd_en.
    logic [DW-1:0] fmem [DEPTH];
    int wp, rp, fcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= 0; rp <= 0; fcnt <= 0; fifo_rdata <= '0;
        end else begin
            if (fifo_wr_en && fcnt < DEPTH) begin
                fmem[wp] <= fifo_wdata;
                wp <= (wp + 1) % DEPTH;
            end
            if (fifo_rd_en && fcnt > 0) begin
                fifo_rdata <= fmem[rp];
                rp <= (rp + 1) % DEPTH;
            end
            fcnt <= fcnt + ((fifo_wr_en && fcnt < DEPTH) ? 1 : 0) - ((fifo_rd_en && fcnt > 0) ? 1 : 0);
        end
    end
    assign fifo_full  = (fcnt == DEPTH);
    assign fifo_empty = (fcnt == 0);

    // Transmitter model: busy from the cycle after tx_start for TX_CYC cycles.
    int tx_left;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         tx_left <= 0;
        else if (tx_start)                  tx_left <= TX_CYC;
        else if (tx_left > 0 && !hold_busy) tx_left <= tx_left - 1;
    end
    assign tx_busy = hold_busy || (tx_left > 0);

    logic [DW-1:0] sb [$];
    logic [DW-1:0] exp_b;
    int n_start = 0, n_done = 0, n_rd = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            check("occupancy", 32'(occupancy), fcnt);
            if (tx_start) begin
                n_start++;
                if (!hold_busy) check("tx_one_in_flight", 32'(tx_busy), 0);
                if (sb.size() == 0) begin
                    check("tx_unexpected", 1, 0);
                end else begin
                    exp_b = sb.pop_front();
                    check("tx_data", 32'(tx_data), 32'(exp_b));
                end
            end
            if (frame_done) n_done++;
            if (fifo_rd_en) n_rd++;
        end
    end

    task automatic send(input logic [DW-1:0] b);
        logic acc;
        @(negedge clk);
        acc = !fifo_full;
        rx_vld = 1'b1;
        rx_data = b;
        if (acc) sb.push_back(b);
        #1 check("wr_en", 32'(fifo_wr_en), 32'(acc));
        @(negedge clk);
        rx_vld = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int start = n_done;
        int n = 0;
        while (n_done == start && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, n_done - start, 1);
        check({tag, "_sb_empty"}, sb.size(), 0);
        check({tag, "_occ_zero"}, 32'(occupancy), 0);
    endtask

    initial begin
        int rd0, st0, n;

        // 1. Reset
        #100;
        check("rst_wr_en", 32'(fifo_wr_en), 0);
        check("rst_rd_en", 32'(fifo_rd_en), 0);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_ovf_err", 32'(ovf_err), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_occupancy", 32'(occupancy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_rd", n_rd, 0);

        // 2. Terminator frame
        st0 = n_start;
        send(8'h41);
        send(8'h42);
        check("term_no_early_rd", n_rd, 0);
        send(8'h0D);
        check("term_occ3", 32'(occupancy), 3);
        check("term_rd_starts", 32'(fifo_rd_en), 1);
        wait_done("term_done", 500);
        check("term_tx_count", n_start - st0, 3);

        // 3. Threshold, plus bytes arriving mid-drain
        rd0 = n_rd;
        for (int i = 0; i < THRESH - 1; i++) send(8'h10 + 8'(i));
        check("thr_no_early_rd", n_rd - rd0, 0);
        send(8'h17);
        check("thr_rd_starts", 32'(fifo_rd_en), 1);
        send(8'h18);
        send(8'h19);
        wait_done("thr_done", 2000);
        st0 = n_done;
        repeat (50) @(negedge clk);
        check("thr_single_done", n_done - st0, 0);

        // 4. Overflow with the transmitter stalled; one byte is already in flight
        hold_busy = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) send(8'h20 + 8'(i));
        check("ovf_occ_full", 32'(occupancy), DEPTH);
        check("ovf_set", 32'(ovf_err), 1);
        repeat (5) @(negedge clk);
        check("ovf_sticky", 32'(ovf_err), 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(ovf_err), 0);
        rx_vld = 1'b1; rx_data = 8'hEE; ovf_clr = 1'b1;
        #1 check("ovf_no_wr_full", 32'(fifo_wr_en), 0);
        @(negedge clk);
        rx_vld = 1'b0; ovf_clr = 1'b0;
        check("ovf_set_wins", 32'(ovf_err), 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_cleared2", 32'(ovf_err), 0);
        hold_busy = 1'b0;
        wait_done("ovf_done", 3000);

        // 5. Write in the same cycle as a FIFO read
        send(8'h51);
        send(8'h0D);
        n = 0;
        while (!fifo_rd_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("sim_rd_seen", 32'(fifo_rd_en), 1);
        rx_vld = 1'b1; rx_data = 8'h55;
        sb.push_back(8'h55);
        @(negedge clk);
        rx_vld = 1'b0;
        check("sim_occ_unchanged", 32'(occupancy), 2);
        wait_done("sim_done", 1000);

        // 6. Partial frame with silence afterwards
        rd0 = n_rd;
        st0 = n_start;
        send(8'h61);
        send(8'h62);
`ifdef UART_FRAME_SCHED_TIMEOUT_EN
        n = 0;
        while (!fifo_rd_en && n < T_CYC + 50) begin
            @(negedge clk);
            n++;
        end
        check("to_flush_delay", n, T_CYC);
        wait_done("to_done", 1000);
        check("to_tx_count", n_start - st0, 2);
`else
        repeat (10 * T_CYC) @(negedge clk);
        check("to_off_no_rd", n_rd - rd0, 0);
        check("to_off_no_tx", n_start - st0, 0);
        check("to_off_occ", 32'(occupancy), 2);
        send(8'h0D);
        wait_done("to_off_done", 1000);
        check("to_off_tx_count", n_start - st0, 3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #4ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
